// File: rtl/router_1xn_top_if.sv
// router_1xn_top_if: packet source / channel read bundle for router_1xn_top.
// The router attaches through the slave modport, the packet source and
// channel readers through the master modport.
interface router_1xn_top_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 3
);
    logic                     packet_valid;
    logic [DATA_W-1:0]        datain;
    logic [NUM_CH-1:0]        read_enb;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        vld_out;
    logic                     busy;
    logic                     err;
    logic [NUM_CH-1:0]        soft_rst;

    modport master (
        output packet_valid, datain, read_enb,
        input  data_out, vld_out, busy, err, soft_rst
    );

    modport slave (
        input  packet_valid, datain, read_enb,
        output data_out, vld_out, busy, err, soft_rst
    );
endinterface

// File: rtl/router_1xn_top.sv
// router_1xn_top: 1-to-N byte-serial packet router.
// Packets (header, payload, parity) arrive on one port and are steered into
// one of NUM_CH per-channel FIFOs by header[ADDR_W-1:0]. Parity mismatch or an
// illegal destination raises a one-cycle err pulse; illegal packets are dropped.
// Optional feature: define ROUTER_TIMEOUT_EN to flush a channel whose data sits
// unread for TIMEOUT cycles (soft_rst pulses); otherwise soft_rst is tied low.
module router_1xn_top #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 30
) (
    input logic             clk,
    input logic             reset,
    router_1xn_top_if.slave bus
);
    localparam int unsigned ADDR_W = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);
    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    // Reject parameter sets the datapath cannot support.
    if (DATA_W < ADDR_W + 1 || NUM_CH < 2 || NUM_CH > 8 || DEPTH < 4 ||
        (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("router_1xn_top: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWaitEmpty,
        StPayload,
        StCheck,
        StDrop
    } state_e;

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_dest, w_dest_d, w_in_dest;
    logic [DATA_W-1:0] r_hdr, w_hdr_d;
    logic [DATA_W-1:0] r_acc, w_acc_d;
    logic [DATA_W-1:0] w_wr_data;
    logic              r_err, w_err_d;
    logic              w_wr_req, w_busy;
    logic              w_in_illegal, w_in_empty, w_dest_empty, w_dest_full;
    logic [NUM_CH-1:0] w_empty, w_full, w_flush;

    assign w_in_dest    = bus.datain[ADDR_W-1:0];
    assign w_in_illegal = ({1'b0, w_in_dest} >= AW1'(NUM_CH));

    // Status of the channel named by the incoming header and by the latched dest.
    always_comb begin
        w_in_empty   = 1'b0;
        w_dest_empty = 1'b0;
        w_dest_full  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_in_dest == ADDR_W'(i)) begin
                w_in_empty = w_empty[i];
            end
            if (r_dest == ADDR_W'(i)) begin
                w_dest_empty = w_empty[i];
                w_dest_full  = w_full[i];
            end
        end
    end

    // Packet FSM next state, FIFO write request, busy and parity accumulation.
    always_comb begin
        w_state_d = r_state;
        w_dest_d  = r_dest;
        w_hdr_d   = r_hdr;
        w_acc_d   = r_acc;
        w_err_d   = 1'b0;
        w_wr_req  = 1'b0;
        w_wr_data = bus.datain;
        w_busy    = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.packet_valid) begin
                    w_dest_d = w_in_dest;
                    if (w_in_illegal) begin
                        w_err_d   = 1'b1;
                        w_state_d = StDrop;
                    end else if (w_in_empty) begin
                        w_wr_req  = 1'b1;
                        w_acc_d   = bus.datain;
                        w_state_d = StPayload;
                    end else begin
                        w_hdr_d   = bus.datain;
                        w_state_d = StWaitEmpty;
                    end
                end
            end
            StWaitEmpty: begin
                // Source holds the first payload byte until the header is stored.
                w_busy = 1'b1;
                if (w_dest_empty) begin
                    w_wr_req  = 1'b1;
                    w_wr_data = r_hdr;
                    w_acc_d   = r_hdr;
                    w_state_d = StPayload;
                end
            end
            StPayload: begin
                // A same-cycle read does not free space for this byte.
                w_busy = w_dest_full;
                if (!w_dest_full) begin
                    w_wr_req = 1'b1;
                    if (bus.packet_valid) begin
                        w_acc_d = r_acc ^ bus.datain;
                    end else begin
                        w_err_d   = (bus.datain != r_acc);
                        w_state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                w_busy    = 1'b1;
                w_acc_d   = '0;
                w_state_d = StIdle;
            end
            StDrop: begin
                if (!bus.packet_valid) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM and packet context registers; err is a registered one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_dest  <= '0;
            r_hdr   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_dest  <= w_dest_d;
            r_hdr   <= w_hdr_d;
            r_acc   <= w_acc_d;
            r_err   <= w_err_d;
        end
    end

    assign bus.busy     = w_busy;
    assign bus.err      = r_err;
    assign bus.vld_out  = ~w_empty;
    assign bus.soft_rst = w_flush;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wptr, r_rptr;
        logic [CNT_W-1:0]  r_cnt;
        logic [DATA_W-1:0] r_dout;
        logic              w_wr, w_rd;

        assign w_empty[g] = (r_cnt == '0);
        assign w_full[g]  = (r_cnt == CNT_W'(DEPTH));
        assign w_rd       = bus.read_enb[g] && !w_empty[g];
        // A flush discards any byte written in the same cycle.
        assign w_wr       = w_wr_req && (w_dest_d == ADDR_W'(g)) && !w_full[g] && !w_flush[g];

        // Storage array written at the tail pointer; contents need no reset.
        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_wr_data;
            end
        end

        // Pointers, occupancy and registered head-word output.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_dout <= '0;
            end else if (w_flush[g]) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_rd) begin
                    r_rptr <= r_rptr + 1'b1;
                    r_dout <= r_mem[r_rptr];
                end
                case ({w_wr, w_rd})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign bus.data_out[g*DATA_W +: DATA_W] = r_dout;

`ifdef ROUTER_TIMEOUT_EN
        localparam int unsigned TCNT_W = $clog2(TIMEOUT);
        logic [TCNT_W-1:0] r_tcnt;
        logic              w_idle_vld;

        assign w_idle_vld = !w_empty[g] && !bus.read_enb[g];
        assign w_flush[g] = w_idle_vld && (r_tcnt == TCNT_W'(TIMEOUT - 1));

        // Idle-read counter: runs while data waits unread, restarts on read, empty or flush.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tcnt <= '0;
            end else if (!w_idle_vld || w_flush[g]) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
`else
        assign w_flush[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_router_1xn_top.sv
// tb_router_1xn_top: directed self-checking bench for router_1xn_top
// (DATA_W=8, NUM_CH=3, DEPTH=16, TIMEOUT=30).
module tb_router_1xn_top;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 30;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;

    router_1xn_top_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    router_1xn_top #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count err pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.err === 1'b1) err_seen++;
    end

    // Present one byte and hold it until an edge with busy low accepts it.
    task automatic send(input logic pv, input logic [7:0] d);
        bit took;
        int n;
        bus.packet_valid = pv;
        bus.datain       = d;
        took = 1'b0;
        n    = 0;
        while (!took && n < 200) begin
            @(negedge clk);
            took = (bus.busy === 1'b0);
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (!took) begin
            n_fail++;
            $display("FAIL send_accept: byte %h still blocked after %0d cycles, required accept", d, n);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.packet_valid = 1'b0;
        bus.datain       = '0;
        bus.read_enb     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: got %h required 0", bus.data_out); end
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL rst_vld_out: got %b required 000", bus.vld_out); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", bus.err); end
        n_checks++;
        if (bus.soft_rst !== 3'b000) begin n_fail++; $display("FAIL rst_soft_rst: got %b required 000", bus.soft_rst); end
        reset = 1'b0;
        // Partial packet, then reset in the middle of it.
        send(1'b1, 8'h22);
        send(1'b1, 8'hA5);
        send(1'b1, 8'h5A);
        n_checks++;
        if (bus.vld_out !== 3'b100) begin n_fail++; $display("FAIL mid_pkt_vld: got %b required 100", bus.vld_out); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL async_rst_vld: got %b required 000", bus.vld_out); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.data_out !== '0) begin
            n_fail++;
            $display("FAIL mid_rst_outputs: busy %b err %b data_out %h required 0 0 0", bus.busy, bus.err, bus.data_out);
        end
        bus.packet_valid = 1'b0;
        reset            = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_packet();
        logic [7:0] exp [10];
        int e0;
        exp = '{8'h22, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hDD};
        e0 = err_seen;
        for (int k = 0; k < 9; k++) send(1'b1, exp[k]);
        send(1'b0, exp[9]);
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL good_err_in_check: got %b required 0", bus.err); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.vld_out !== 3'b100) begin n_fail++; $display("FAIL good_vld: got %b required 100", bus.vld_out); end
        bus.read_enb = 3'b100;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[23:16] !== exp[k]) begin
                n_fail++;
                $display("FAIL good_word%0d: got %h required %h", k, bus.data_out[23:16], exp[k]);
            end
        end
        n_checks++;
        if (bus.vld_out[2] !== 1'b0) begin n_fail++; $display("FAIL good_vld_after: got %b required 0", bus.vld_out[2]); end
        bus.read_enb = '0;
        n_checks++;
        if (err_seen - e0 !== 0) begin n_fail++; $display("FAIL good_err_count: got %0d required 0", err_seen - e0); end
    endtask

    task automatic test_bad_parity();
        logic [7:0] exp [7];
        int e0;
        exp = '{8'h15, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h33, 8'h27};
        e0 = err_seen;
        for (int k = 0; k < 6; k++) send(1'b1, exp[k]);
        send(1'b0, exp[6]);
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_check_cycle: err %b busy %b required 1 1", bus.err, bus.busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bad_err_width: got %b required 0", bus.err); end
        n_checks++;
        if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL bad_err_count: got %0d required 1", err_seen - e0); end
        bus.read_enb = 3'b010;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[15:8] !== exp[k]) begin
                n_fail++;
                $display("FAIL bad_word%0d: got %h required %h", k, bus.data_out[15:8], exp[k]);
            end
        end
        bus.read_enb = '0;
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL bad_vld_after: got %b required 000", bus.vld_out); end
    endtask

    task automatic test_full();
        logic [7:0] exp [22];
        logic [7:0] got [$];
        bit         hold_ok;
        exp[0]  = 8'h50;
        for (int k = 1; k <= 20; k++) exp[k] = 8'(k);
        exp[21] = 8'h44;
        for (int k = 0; k < 16; k++) send(1'b1, exp[k]);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.vld_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_busy: busy %b vld0 %b required 1 1", bus.busy, bus.vld_out[0]);
        end
        bus.packet_valid = 1'b1;
        bus.datain       = exp[16];
        hold_ok          = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) hold_ok = 1'b0;
        end
        n_checks++;
        if (!hold_ok) begin n_fail++; $display("FAIL full_busy_hold: got busy drop while full, required 1"); end
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 16; k <= 20; k++) send(1'b1, exp[k]);
                send(1'b0, exp[21]);
            end
            begin
                bit v;
                int cyc;
                cyc = 0;
                bus.read_enb = 3'b001;
                while (got.size() < 22 && cyc < 400) begin
                    @(negedge clk);
                    v = bus.vld_out[0];
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (v) got.push_back(bus.data_out[7:0]);
                end
                bus.read_enb = '0;
            end
        join
        n_checks++;
        if (got.size() != 22) begin n_fail++; $display("FAIL full_count: got %0d words required 22", got.size()); end
        for (int k = 0; k < 22 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp[k]) begin n_fail++; $display("FAIL full_word%0d: got %h required %h", k, got[k], exp[k]); end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL full_vld_after: got %b required 000", bus.vld_out); end
    endtask

    task automatic test_illegal_addr();
        int e0;
        e0 = err_seen;
        send(1'b1, 8'h13);
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err: err %b busy %b required 1 0", bus.err, bus.busy);
        end
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        send(1'b1, 8'h44);
        send(1'b0, 8'h00);
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL illegal_no_write: got %b required 000", bus.vld_out); end
        // Zero-length packet to ch1 right after the dropped one.
        send(1'b1, 8'h01);
        send(1'b0, 8'h01);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.vld_out !== 3'b010) begin n_fail++; $display("FAIL illegal_next_vld: got %b required 010", bus.vld_out); end
        n_checks++;
        if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL illegal_err_count: got %0d required 1", err_seen - e0); end
        bus.read_enb = 3'b010;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[15:8] !== 8'h01) begin
                n_fail++;
                $display("FAIL illegal_next_word%0d: got %h required 01", k, bus.data_out[15:8]);
            end
        end
        bus.read_enb = '0;
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL illegal_vld_after: got %b required 000", bus.vld_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        logic [7:0] exp_c [4];
        bit         hold_ok;
        int         e0;
        exp_a = '{8'h06, 8'h5A, 8'h5C};
        exp_b = '{8'h04, 8'hC3, 8'hC7};
        exp_c = '{8'h0A, 8'h11, 8'h22, 8'h39};
        e0 = err_seen;
        send(1'b1, exp_a[0]);
        send(1'b1, exp_a[1]);
        send(1'b0, exp_a[2]);
        send(1'b1, exp_b[0]);
        send(1'b1, exp_b[1]);
        send(1'b0, exp_b[2]);
        // Header to a non-empty ch2 parks in the wait state.
        send(1'b1, exp_c[0]);
        bus.packet_valid = 1'b1;
        bus.datain       = exp_c[1];
        hold_ok          = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) hold_ok = 1'b0;
        end
        n_checks++;
        if (!hold_ok) begin n_fail++; $display("FAIL wait_busy: got busy low while ch2 occupied, required 1"); end
        @(posedge clk);
        #1;
        bus.read_enb = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[23:16] !== exp_a[k]) begin
                n_fail++;
                $display("FAIL b2b_a_word%0d: got %h required %h", k, bus.data_out[23:16], exp_a[k]);
            end
        end
        bus.read_enb = '0;
        send(1'b1, exp_c[1]);
        send(1'b1, exp_c[2]);
        send(1'b0, exp_c[3]);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.vld_out !== 3'b101) begin n_fail++; $display("FAIL b2b_vld: got %b required 101", bus.vld_out); end
        bus.read_enb = 3'b100;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[23:16] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL b2b_c_word%0d: got %h required %h", k, bus.data_out[23:16], exp_c[k]);
            end
        end
        bus.read_enb = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[7:0] !== exp_b[k]) begin
                n_fail++;
                $display("FAIL b2b_b_word%0d: got %h required %h", k, bus.data_out[7:0], exp_b[k]);
            end
        end
        bus.read_enb = '0;
        n_checks++;
        if (bus.vld_out !== 3'b000 || err_seen - e0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_end: vld %b errs %0d required 000 0", bus.vld_out, err_seen - e0);
        end
    endtask

    task automatic test_timeout();
`ifdef ROUTER_TIMEOUT_EN
        int first;
        int hits;
        first = 0;
        hits  = 0;
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        for (int k = 2; k <= 45; k++) begin
            @(negedge clk);
            if (bus.soft_rst !== 3'b000) begin
                hits++;
                if (first == 0) first = k;
            end
        end
        n_checks++;
        if (first != 30) begin n_fail++; $display("FAIL timeout_cycle: got %0d required 30", first); end
        n_checks++;
        if (hits != 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d cycles required 1", hits); end
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL timeout_flush: got %b required 000", bus.vld_out); end
`else
        bit quiet;
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.soft_rst !== 3'b000) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL retain_soft_rst: got pulse required none"); end
        n_checks++;
        if (bus.vld_out !== 3'b001) begin n_fail++; $display("FAIL retain_vld: got %b required 001", bus.vld_out); end
        @(posedge clk);
        #1;
        bus.read_enb = 3'b001;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.data_out[7:0] !== 8'h00) begin
                n_fail++;
                $display("FAIL retain_word%0d: got %h required 00", k, bus.data_out[7:0]);
            end
        end
        bus.read_enb = '0;
        n_checks++;
        if (bus.vld_out !== 3'b000) begin n_fail++; $display("FAIL retain_vld_after: got %b required 000", bus.vld_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_full();
        test_illegal_addr();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
